// File: rtl/adder_pkg.sv
// Shared constants and the second-level carry-lookahead function for the
// 32-bit KGP-RISC ALU adder.
package adder_pkg;

  localparam int WIDTH      = 32;
  localparam int SLICE_W    = 4;
  localparam int NSLICE     = WIDTH / SLICE_W;

  // Flat sum-of-products lookahead: the carry into group k is expanded
  // directly from every lower group's G/P and the block carry-in, so no
  // group carry waits on another group carry.
  function automatic logic [NSLICE:0] group_carries(
    input logic [NSLICE-1:0] g,
    input logic [NSLICE-1:0] p,
    input logic              c0
  );
    logic [NSLICE:0] c;
    logic            term;
    c    = '0;
    c[0] = c0;
    for (int k = 1; k <= NSLICE; k++) begin
      term = c0;
      for (int j = 0; j < k; j++) term = term & p[j];
      c[k] = term;
      for (int j = 0; j < k; j++) begin
        term = g[j];
        for (int m = j + 1; m < k; m++) term = term & p[m];
        c[k] = c[k] | term;
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/cla_4bit.sv
// 4-bit carry-lookahead slice: local sum bits from the slice carry-in plus
// group generate/propagate for the second-level lookahead.
module cla_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       G,
  output logic       P
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  assign g = a & b;
  assign p = a ^ b;

  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & ci);

  assign s = p ^ c;

  assign G = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
           | (p[3] & p[2] & p[1] & g[0]);
  assign P = &p;

endmodule

// File: rtl/adder.sv
// 32-bit adder with carry-in/out: eight 4-bit CLA slices, a second-level
// lookahead over the slice G/P, and a one-cycle output register.
module adder
  import adder_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [NSLICE-1:0] grp_g;
  logic [NSLICE-1:0] grp_p;
  logic [NSLICE:0]   grp_c;
  logic [WIDTH-1:0]  sum_d;

  for (genvar k = 0; k < NSLICE; k++) begin : g_slice
    cla_4bit u_cla (
      .a  (A[k*SLICE_W +: SLICE_W]),
      .b  (B[k*SLICE_W +: SLICE_W]),
      .ci (grp_c[k]),
      .s  (sum_d[k*SLICE_W +: SLICE_W]),
      .G  (grp_g[k]),
      .P  (grp_p[k])
    );
  end

  assign grp_c = group_carries(grp_g, grp_p, cin);

  // No handshake: a new operand set is captured on every rising edge and its
  // result is visible on sum/cout after that edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum  <= '0;
      cout <= 1'b0;
    end else begin
      sum  <= sum_d;
      cout <= grp_c[NSLICE];
    end
  end

endmodule

// File: tb/tb_adder.sv
// Self-checking bench for the registered 32-bit adder against a 33-bit
// arithmetic reference model.
module tb_adder;

  logic        clk;
  logic        rst_n;
  logic [31:0] A;
  logic [31:0] B;
  logic        cin;
  logic [31:0] sum;
  logic        cout;

  int checks;
  int errors;

  logic [32:0] exp_q[$];

  adder dut (
    .clk  (clk),
    .rst_n(rst_n),
    .A    (A),
    .B    (B),
    .cin  (cin),
    .sum  (sum),
    .cout (cout)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [32:0] ref_add(input logic [31:0] a, input logic [31:0] b,
                                          input logic c);
    logic [32:0] r;
    r = {1'b0, a} + {1'b0, b} + {32'd0, c};
    return r;
  endfunction

  // ---------------- driver ----------------
  task automatic drive_op(input logic [31:0] a, input logic [31:0] b, input logic c);
    @(negedge clk);
    A   = a;
    B   = b;
    cin = c;
    exp_q.push_back(ref_add(a, b, c));
  endtask

  function automatic logic [31:0] rand_operand();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0:       v = 32'hFFFF_FFFF;
      1:       v = 32'h0000_0000;
      2:       v = 32'h8000_0000;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [32:0] exp;
    rst_n = 1'b0;
    A     = 32'hCCC9_CCC9;
    B     = 32'h3273_39C9;
    cin   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({cout, sum} !== 33'h0) begin
      errors++;
      $display("FAIL reset_hold: got sum=%h cout=%b expected sum=00000000 cout=0", sum, cout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp = ref_add(A, B, cin);
    @(posedge clk);
    #1;
    checks++;
    if ({cout, sum} !== 33'h0_FF3D_0692 || {cout, sum} !== exp) begin
      errors++;
      $display("FAIL reset_release: got sum=%h cout=%b expected sum=FF3D0692 cout=0", sum, cout);
    end
  endtask

  task automatic test_directed();
    logic [31:0] ta [7];
    logic [31:0] tb [7];
    logic        tc [7];
    logic [32:0] fixed [7];
    logic [32:0] exp;
    ta = '{32'hCCC9_CCC9, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h5};
    tb = '{32'hF273_39C9, 32'h0, 32'h0, 32'h0, 32'h1, 32'hFFFF_FFFF, ~32'h5};
    tc = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    fixed = '{33'h1_BF3D_0692, 33'h0_0000_0000, 33'h0_0000_0001, 33'h1_0000_0000,
              33'h1_0000_0000, 33'h1_FFFF_FFFF, 33'h1_0000_0000};
    for (int i = 0; i < 7; i++) begin
      drive_op(ta[i], tb[i], tc[i]);
      @(posedge clk);
      #1;
      exp = exp_q.pop_front();
      checks++;
      if ({cout, sum} !== exp || exp !== fixed[i]) begin
        errors++;
        $display("FAIL directed_%0d: got sum=%h cout=%b expected sum=%h cout=%b",
                 i, sum, cout, fixed[i][31:0], fixed[i][32]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [32:0] exp;
    for (int i = 0; i < 16; i++) begin
      drive_op($urandom, $urandom, 1'($urandom_range(0, 1)));
      @(posedge clk);
      #1;
      exp = exp_q.pop_front();
      checks++;
      if ({cout, sum} !== exp) begin
        errors++;
        $display("FAIL back_to_back_%0d: got sum=%h cout=%b expected sum=%h cout=%b",
                 i, sum, cout, exp[31:0], exp[32]);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [32:0] exp;
    drive_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    @(posedge clk);
    #1;
    exp = exp_q.pop_front();
    checks++;
    if ({cout, sum} !== exp) begin
      errors++;
      $display("FAIL pre_reset: got sum=%h cout=%b expected sum=%h cout=%b",
               sum, cout, exp[31:0], exp[32]);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({cout, sum} !== 33'h0) begin
      errors++;
      $display("FAIL async_clear: got sum=%h cout=%b expected sum=00000000 cout=0", sum, cout);
    end
    drive_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
    exp_q.delete();
    @(posedge clk);
    #1;
    checks++;
    if ({cout, sum} !== 33'h0) begin
      errors++;
      $display("FAIL reset_held_edge: got sum=%h cout=%b expected sum=00000000 cout=0", sum, cout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp = ref_add(A, B, cin);
    @(posedge clk);
    #1;
    checks++;
    if ({cout, sum} !== exp) begin
      errors++;
      $display("FAIL post_reset: got sum=%h cout=%b expected sum=%h cout=%b",
               sum, cout, exp[31:0], exp[32]);
    end
  endtask

  task automatic test_random();
    logic [32:0] exp;
    int          local_err;
    local_err = 0;
    for (int i = 0; i < 10000; i++) begin
      drive_op(rand_operand(), rand_operand(), 1'($urandom_range(0, 1)));
      @(posedge clk);
      #1;
      exp = exp_q.pop_front();
      checks++;
      if ({cout, sum} !== exp) begin
        errors++;
        local_err++;
        if (local_err <= 10)
          $display("FAIL random_%0d: A=%h B=%h cin=%b got sum=%h cout=%b expected sum=%h cout=%b",
                   i, A, B, cin, sum, cout, exp[31:0], exp[32]);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
